// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port (ICache/DCache) memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LINE_W  = 128;
  localparam int DEF_LATENCY = 5;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IC,
    OWNER_DC
  } owner_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever did not own last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = ic_req | dc_req;
    grant_owner = OWNER_IC;
    if (ic_req && dc_req) begin
      grant_owner = (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
    end else if (dc_req) begin
      grant_owner = OWNER_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ICache refills and DCache refills/writebacks onto one fixed-latency memory port.
// Handshake: a requester raises req with stable addr/data and holds it until its one-cycle
// resp_valid; the arbiter latches the transaction at grant, so later input changes are ignored.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_t        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            last_owner_q, last_owner_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;

  logic   grant_valid;
  owner_t grant_owner;

  mem_arb_rr u_rr (
    .ic_req      (ic_req),
    .dc_req      (dc_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWNER_IC;
      owner_q      <= OWNER_IC;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d      = ARB_BUSY;
          cnt_d        = CNT_LOAD;
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          if (grant_owner == OWNER_DC) begin
            addr_d  = dc_addr;
            we_d    = dc_we;
            wdata_d = dc_wdata;
          end else begin
            addr_d  = ic_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          // Only reads land in the owner's line register; writes leave it alone.
          if (!we_q) begin
            if (owner_q == OWNER_DC) dc_rdata_d = mem_rdata;
            else                     ic_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ARB_IDLE);
    mem_en        = (state_q == ARB_BUSY);
    mem_we        = (state_q == ARB_BUSY) && (cnt_q == '0) && we_q;
    ic_resp_valid = (state_q == ARB_RESP) && (owner_q == OWNER_IC);
    dc_resp_valid = (state_q == ARB_RESP) && (owner_q == OWNER_DC);
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    ic_rdata      = ic_rdata_q;
    dc_rdata      = dc_rdata_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int LAT = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // main DUT (LATENCY=5)
  logic          ic_req, ic_resp_valid, dc_req, dc_we, dc_resp_valid;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic [LW-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
  arb_state_t    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp_valid(ic_resp_valid), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // second DUT (LATENCY=1)
  logic          d1_ic_req, d1_ic_resp_valid, d1_dc_req, d1_dc_we, d1_dc_resp_valid;
  logic          d1_mem_en, d1_mem_we, d1_busy;
  logic [AW-1:0] d1_ic_addr, d1_dc_addr, d1_mem_addr;
  logic [LW-1:0] d1_ic_rdata, d1_dc_rdata, d1_dc_wdata, d1_mem_wdata, d1_mem_rdata;
  arb_state_t    d1_dbg_state;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .ic_req(d1_ic_req), .ic_addr(d1_ic_addr), .ic_resp_valid(d1_ic_resp_valid), .ic_rdata(d1_ic_rdata),
    .dc_req(d1_dc_req), .dc_we(d1_dc_we), .dc_addr(d1_dc_addr), .dc_wdata(d1_dc_wdata),
    .dc_resp_valid(d1_dc_resp_valid), .dc_rdata(d1_dc_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(d1_mem_rdata), .busy(d1_busy), .dbg_state(d1_dbg_state)
  );

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0F0F, ~a, a * 32'd3, a + 32'h1111_0000};
  endfunction

  // environment memory driven by the DUT
  logic [LW-1:0] mem_arr [logic [AW-1:0]];
  int unsigned   mem_ver = 0;

  always @(mem_addr or mem_ver)
    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : default_line(mem_addr);

  always @(negedge clock)
    if (reset && mem_we) begin
      mem_arr[mem_addr] = mem_wdata;
      mem_ver++;
    end

  assign d1_mem_rdata = default_line(d1_mem_addr);

  // reference model state
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  owner_t        model_last;
  logic [LW-1:0] exp_rdata [2];
  logic [LW-1:0] exp_q [$];
  logic          pend [2];
  logic [AW-1:0] p_addr [2];
  logic          p_we [2];
  logic [LW-1:0] p_wdata [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic post_req(input owner_t o, input logic [AW-1:0] a, input logic we,
                          input logic [LW-1:0] wd);
    int i;
    i = int'(o);
    pend[i]    = 1'b1;
    p_addr[i]  = a;
    p_we[i]    = (o == OWNER_DC) ? we : 1'b0;
    p_wdata[i] = (o == OWNER_DC) ? wd : '0;
    if (o == OWNER_IC) begin
      ic_req  = 1'b1;
      ic_addr = a;
    end else begin
      dc_req   = 1'b1;
      dc_we    = we;
      dc_addr  = a;
      dc_wdata = wd;
    end
  endtask

  // Called during an IDLE cycle with requests already on the pins; runs one full transaction.
  task automatic serve(output owner_t o);
    int i, j;
    logic [LW-1:0] line;
    if (pend[0] && pend[1]) o = (model_last == OWNER_IC) ? OWNER_DC : OWNER_IC;
    else                    o = pend[1] ? OWNER_DC : OWNER_IC;
    model_last = o;
    i = int'(o);
    j = 1 - i;
    exp_q.push_back(p_we[i] ? exp_rdata[i] : ref_rd(p_addr[i]));
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1) begin
        if (o == OWNER_IC) ic_addr = $urandom;
        else begin
          dc_addr  = $urandom;
          dc_wdata = {$urandom, $urandom, $urandom, $urandom};
          dc_we    = 1'($urandom_range(0, 1));
        end
      end
      check("busy_mem_en", mem_en, 1'b1);
      check("busy_flag", busy, 1'b1);
      check("busy_state", dbg_state, ARB_BUSY);
      check("mem_addr", mem_addr, p_addr[i]);
      check("mem_wdata", mem_wdata, p_wdata[i]);
      check("mem_we", mem_we, p_we[i] && (k == LAT));
      check("busy_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
    end
    step();
    check("resp_owner", {dc_resp_valid, ic_resp_valid}, (o == OWNER_DC) ? 2'b10 : 2'b01);
    check("resp_mem_en", mem_en, 1'b0);
    check("resp_mem_we", mem_we, 1'b0);
    line = exp_q.pop_front();
    if (!p_we[i]) exp_rdata[i] = line;
    else begin
      ref_mem[p_addr[i]] = p_wdata[i];
      check("mem_written", mem_arr.exists(p_addr[i]) ? mem_arr[p_addr[i]] : '0, p_wdata[i]);
    end
    check("rdata_owner", (o == OWNER_DC) ? dc_rdata : ic_rdata, line);
    check("rdata_other", (o == OWNER_DC) ? ic_rdata : dc_rdata, exp_rdata[j]);
    pend[i] = 1'b0;
    if (o == OWNER_IC) ic_req = 1'b0;
    else               dc_req = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);
    check("idle_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 7)) * 32'h40;
  endfunction

  initial begin
    owner_t o;
    logic [LW-1:0] wd;
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    d1_ic_req = 0; d1_ic_addr = '0; d1_dc_req = 0; d1_dc_we = 0; d1_dc_addr = '0; d1_dc_wdata = '0;
    model_last = OWNER_IC;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    pend[0] = 0; pend[1] = 0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {ic_resp_valid, dc_resp_valid, mem_en, mem_we, busy}, 5'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_rdata", ic_rdata | dc_rdata | mem_wdata, '0);
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_d1", {d1_mem_en, d1_busy, d1_ic_resp_valid}, 3'b0);
    reset = 1'b1;
    step();

    // tie right after reset: DCache first, ICache next
    post_req(OWNER_IC, 32'h80, 1'b0, '0);
    post_req(OWNER_DC, 32'hC0, 1'b0, '0);
    serve(o); check("tie_first_dc", o, OWNER_DC);
    serve(o); check("tie_second_ic", o, OWNER_IC);

    // lone ICache read
    post_req(OWNER_IC, 32'h40, 1'b0, '0);
    serve(o);

    // both re-requesting: strict alternation
    post_req(OWNER_IC, rand_addr(), 1'b0, '0);
    post_req(OWNER_DC, rand_addr(), 1'b0, '0);
    for (int n = 0; n < 6; n++) begin
      serve(o);
      check("alternate", o, (n % 2 == 0) ? OWNER_DC : OWNER_IC);
      post_req(o, rand_addr(), 1'b0, '0);
    end
    while (pend[0] || pend[1]) serve(o);

    // DCache writeback then read-back
    post_req(OWNER_DC, 32'h100, 1'b1, 128'hDEADBEEF_00000000_CAFEF00D_12345678);
    serve(o);
    post_req(OWNER_IC, 32'h100, 1'b0, '0);
    serve(o);

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      if (!pend[0] && $urandom_range(0, 2) != 0) post_req(OWNER_IC, rand_addr(), 1'b0, '0);
      if (!pend[1] && $urandom_range(0, 2) != 0) begin
        wd = {$urandom, $urandom, $urandom, $urandom};
        post_req(OWNER_DC, rand_addr(), 1'($urandom_range(0, 1)), wd);
      end
      if (!pend[0] && !pend[1]) post_req(OWNER_IC, rand_addr(), 1'b0, '0);
      serve(o);
    end
    while (pend[0] || pend[1]) serve(o);

    // reset in BUSY cycle 3 of a write
    post_req(OWNER_DC, 32'h1C0, 1'b1, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("abort_outputs", {ic_resp_valid, dc_resp_valid, mem_en, mem_we, busy}, 5'b0);
    check("abort_regs", mem_addr | mem_wdata | ic_rdata | dc_rdata, '0);
    model_last = OWNER_IC;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_q.delete();
    pend[0] = 0; pend[1] = 0; ic_req = 0; dc_req = 0;
    step();
    check("abort_hold", {dc_resp_valid, mem_we, busy}, 3'b0);
    reset = 1'b1;
    step();
    check("abort_no_write", mem_arr.exists(32'h1C0) ? mem_arr[32'h1C0] : '0,
          ref_mem.exists(32'h1C0) ? ref_mem[32'h1C0] : '0);
    post_req(OWNER_IC, 32'h1C0, 1'b0, '0);
    post_req(OWNER_DC, 32'h1C0, 1'b0, '0);
    serve(o); check("post_abort_tie", o, OWNER_DC);
    serve(o);

    // LATENCY=1 instance, lone ICache read
    d1_ic_req  = 1'b1;
    d1_ic_addr = 32'h40;
    step();
    check("l1_c1_en", {d1_mem_en, d1_ic_resp_valid}, 2'b10);
    check("l1_c1_addr", d1_mem_addr, 32'h40);
    step();
    check("l1_c2_resp", {d1_mem_en, d1_ic_resp_valid, d1_dc_resp_valid}, 3'b010);
    check("l1_c2_rdata", d1_ic_rdata, default_line(32'h40));
    d1_ic_req = 1'b0;
    step();
    check("l1_idle", {d1_busy, d1_ic_resp_valid}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request/memory address width in bits.
REQ-002 Parameter LINE_W, default 128, cache-line data width in bits.
REQ-003 Parameter LATENCY, default 5, memory access cycles; legal range 1..15.
REQ-004 clock  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-006 ic_req  in  1  ICache refill request; held high until ic_resp_valid.
REQ-007 ic_addr  in  ADDR_W  ICache line address.
REQ-008 ic_resp_valid  out  1  one-cycle pulse: ICache refill complete.
REQ-009 ic_rdata  out  LINE_W  ICache refill line; valid with ic_resp_valid.
REQ-010 dc_req  in  1  DCache request (refill or writeback); held high until dc_resp_valid.
REQ-011 dc_we  in  1  DCache request is a line write.
REQ-012 dc_addr  in  ADDR_W  DCache line address.
REQ-013 dc_wdata  in  LINE_W  DCache writeback line.
REQ-014 dc_resp_valid  out  1  one-cycle pulse: DCache access complete.
REQ-015 dc_rdata  out  LINE_W  DCache refill line; valid with dc_resp_valid.
REQ-016 mem_en  out  1  shared memory access active.
REQ-017 mem_we  out  1  single-cycle memory write strobe.
REQ-018 mem_addr  out  ADDR_W  latched address of the granted request.
REQ-019 mem_wdata  out  LINE_W  latched write data of the granted request.
REQ-020 mem_rdata  in  LINE_W  combinational memory read data for mem_addr.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states IDLE, BUSY, RESP; BUSY holds a down-counter cnt of 4 bits.
REQ-023 IDLE: if any req is high, grant one, latch its addr, we and wdata (wdata forced 0 for ICache), load cnt=LATENCY-1, go BUSY; otherwise stay in IDLE.
REQ-024 Arbitration: a lone request is granted immediately; on a tie, the requester other than last_owner is granted; last_owner is updated on every grant.
REQ-025 BUSY: mem_en=1; mem_addr and mem_wdata are driven from the latched registers; cnt decrements each cycle; at cnt==0, capture mem_rdata into the owner's rdata register (reads only) and go RESP.
REQ-026 mem_we is asserted only in the final BUSY cycle (cnt==0) of a write, exactly once per write.
REQ-027 RESP: assert the owner's resp_valid for exactly one cycle, go IDLE; mem_en=0.
REQ-028 Latency: req sampled high in IDLE at edge E -> BUSY for LATENCY cycles -> resp_valid in cycle E+LATENCY+1.
REQ-029 Requesters drop req at the edge ending their resp_valid cycle; the IDLE after RESP therefore sees a fresh request only.
REQ-030 req deassertion and addr/wdata changes during BUSY/RESP are ignored; the latched transaction completes and resp_valid still pulses.
REQ-031 A write leaves the owner's rdata register unchanged; rdata registers hold until the next read completes for that owner.
REQ-032 Requests are never queued; a non-granted requester is re-arbitrated in the next IDLE cycle.

Reset
REQ-033 reset=0 immediately forces state=IDLE, cnt=0, last_owner=IC, latched regs=0, all outputs 0 (including mem_we), independent of clock.
REQ-034 Reset mid-transaction aborts it without write strobe or resp_valid; the first tie after release is granted to DCache.

Structure
REQ-035 Package mem_arb_pkg holds arb_state_t {ARB_IDLE, ARB_BUSY, ARB_RESP}, owner_t {OWNER_IC, OWNER_DC} and default LINE_W/ADDR_W/LATENCY constants.
REQ-036 Sub-module mem_arb_rr (combinational 2-way round-robin picker: ic_req, dc_req, last_owner -> grant_valid, grant_owner) is instantiated once.

Verification (LATENCY=5, cycle 0 = first edge with req high in IDLE)
REQ-037 ic_req alone, ic_addr=0x40 -> mem_en cycles 1-5, mem_addr=0x40, ic_resp_valid cycle 6 only, ic_rdata=model line @0x40, dc_resp_valid never high.
REQ-038 ic_req and dc_req both high right after reset -> DCache served first (dc_resp_valid cycle 6), ICache next (ic_resp_valid cycle 13).
REQ-039 Both requesters continuously re-requesting for 6 transactions -> owners alternate DC,IC,DC,IC,DC,IC; no starvation.
REQ-040 dc_we=1, dc_addr=0x100, dc_wdata=0xDEADBEEF_00000000_CAFEF00D_12345678 -> mem_we high in cycle 5 only, model line updated, dc_resp_valid cycle 6, dc_rdata unchanged.
REQ-041 reset pulled low in BUSY cycle 3 of a write -> all outputs 0 in the same cycle, no mem_we, model unchanged; after release a tie is granted to DCache.
REQ-042 LATENCY=1, ic_req alone -> mem_en in cycle 1 only, ic_resp_valid in cycle 2.
